// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : Registered decode stage feeding imm_mux. Accepts one
//               instruction/PC over valid/ready, decodes the opcode into an
//               immediate type and registers all five sign-extended
//               immediates. Holds one instruction; supports stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  imm_type,
  output logic [31:0] imm_J,
  output logic [31:0] imm_U,
  output logic [31:0] imm_B,
  output logic [31:0] imm_S,
  output logic [31:0] imm_I,
  output logic        illegal
);

  // Immediate type encodings as seen by imm_mux
  localparam logic [2:0] c_TYPE_J    = 3'b000;
  localparam logic [2:0] c_TYPE_U    = 3'b001;
  localparam logic [2:0] c_TYPE_B    = 3'b010;
  localparam logic [2:0] c_TYPE_S    = 3'b011;
  localparam logic [2:0] c_TYPE_I    = 3'b100;
  localparam logic [2:0] c_TYPE_NONE = 3'b101;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  logic        r_out_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [2:0]  r_imm_type;
  logic [31:0] r_imm_j;
  logic [31:0] r_imm_u;
  logic [31:0] r_imm_b;
  logic [31:0] r_imm_s;
  logic [31:0] r_imm_i;
  logic        r_illegal;

  logic        w_capture;
  logic [2:0]  w_imm_type;
  logic        w_illegal;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_i;

  // Ready depends only on registered state, never on the incoming instruction
  assign in_ready  = !r_out_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  // Immediate extraction; every format is produced for every instruction
  assign w_imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
  assign w_imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign w_imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};
  assign w_imm_u = {instr_in[31:12], 12'b0};
  assign w_imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                    instr_in[20], instr_in[30:21], 1'b0};

  // Opcode decode into immediate type; unknown opcodes are flagged illegal
  always_comb begin
    w_imm_type = c_TYPE_NONE;
    w_illegal  = 1'b0;
    case (instr_in[6:0])
      c_OP_JAL:                          w_imm_type = c_TYPE_J;
      c_OP_LUI, c_OP_AUIPC:              w_imm_type = c_TYPE_U;
      c_OP_BRANCH:                       w_imm_type = c_TYPE_B;
      c_OP_STORE:                        w_imm_type = c_TYPE_S;
      c_OP_OPIMM, c_OP_LOAD, c_OP_JALR:  w_imm_type = c_TYPE_I;
      c_OP_OP, c_OP_FENCE, c_OP_SYSTEM:  w_imm_type = c_TYPE_NONE;
      default: begin
        w_imm_type = c_TYPE_NONE;
        w_illegal  = 1'b1;
      end
    endcase
  end

  // Pipeline register: flush beats capture and stall; consume just drops valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_pc        <= RESET_PC;
      r_imm_type  <= c_TYPE_NONE;
      r_imm_j     <= 32'h0;
      r_imm_u     <= 32'h0;
      r_imm_b     <= 32'h0;
      r_imm_s     <= 32'h0;
      r_imm_i     <= 32'h0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_imm_type  <= c_TYPE_NONE;
      r_illegal   <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_instr     <= instr_in;
      r_pc        <= pc_in;
      r_imm_type  <= w_imm_type;
      r_imm_j     <= w_imm_j;
      r_imm_u     <= w_imm_u;
      r_imm_b     <= w_imm_b;
      r_imm_s     <= w_imm_s;
      r_imm_i     <= w_imm_i;
      r_illegal   <= w_illegal;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign instr_out = r_instr;
  assign pc_out    = r_pc;
  assign imm_type  = r_imm_type;
  assign imm_J     = r_imm_j;
  assign imm_U     = r_imm_u;
  assign imm_B     = r_imm_b;
  assign imm_S     = r_imm_s;
  assign imm_I     = r_imm_i;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_stage
// Description : Self-checking bench for imm_gen_stage. A negedge monitor keeps
//               a scoreboard of the instruction the stage should be holding;
//               directed checks cover reset, flush, stall and illegal decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  imm_type;
  logic [31:0] imm_J;
  logic [31:0] imm_U;
  logic [31:0] imm_B;
  logic [31:0] imm_S;
  logic [31:0] imm_I;
  logic        illegal;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  t;
    logic [31:0] j;
    logic [31:0] u;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] i;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  imm_gen_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .instr_out (instr_out),
    .pc_out    (pc_out),
    .imm_type  (imm_type),
    .imm_J     (imm_J),
    .imm_U     (imm_U),
    .imm_B     (imm_B),
    .imm_S     (imm_S),
    .imm_I     (imm_I),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Reference decode of one instruction
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] p);
    exp_t e;
    e.instr = x;
    e.pc    = p;
    e.ill   = 1'b0;
    case (x[6:0])
      7'h6F:                e.t = 3'd0;
      7'h37, 7'h17:         e.t = 3'd1;
      7'h63:                e.t = 3'd2;
      7'h23:                e.t = 3'd3;
      7'h13, 7'h03, 7'h67:  e.t = 3'd4;
      7'h33, 7'h0F, 7'h73:  e.t = 3'd5;
      default: begin
        e.t   = 3'd5;
        e.ill = 1'b1;
      end
    endcase
    e.i = {{20{x[31]}}, x[31:20]};
    e.s = {{20{x[31]}}, x[31:25], x[11:7]};
    e.b = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
    e.u = {x[31:12], 12'b0};
    e.j = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
    return e;
  endfunction

  // Scoreboard monitor: compare the held instruction, then predict the edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check("out_valid", {31'b0, out_valid}, {31'b0, sb_q.size() != 0});
      check("in_ready", {31'b0, in_ready}, {31'b0, (sb_q.size() == 0) || out_ready});
      if (out_valid && sb_q.size() != 0) begin
        check("sb_instr", instr_out, sb_q[0].instr);
        check("sb_pc", pc_out, sb_q[0].pc);
        check("sb_type", {29'b0, imm_type}, {29'b0, sb_q[0].t});
        check("sb_imm_J", imm_J, sb_q[0].j);
        check("sb_imm_U", imm_U, sb_q[0].u);
        check("sb_imm_B", imm_B, sb_q[0].b);
        check("sb_imm_S", imm_S, sb_q[0].s);
        check("sb_imm_I", imm_I, sb_q[0].i);
        check("sb_illegal", {31'b0, illegal}, {31'b0, sb_q[0].ill});
      end
      if (flush) begin
        if (sb_q.size() != 0) void'(sb_q.pop_front());
      end else begin
        if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
        if (in_valid && (sb_q.size() == 0)) sb_q.push_back(model(instr_in, pc_in));
      end
    end
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] p);
    in_valid = 1'b1;
    instr_in = x;
    pc_in    = p;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_instr"}, instr_out, 32'h0000_0013);
    check({tag, "_pc"}, pc_out, 32'h0);
    check({tag, "_type"}, {29'b0, imm_type}, 32'h5);
    check({tag, "_immI"}, imm_I, 32'h0);
    check({tag, "_immJ"}, imm_J, 32'h0);
    check({tag, "_ill"}, {31'b0, illegal}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    instr_in  = 32'h0;
    pc_in     = 32'h0;
    tick();
    tick();
    check_reset_vals("rst");
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    rst_n = 1'b1;

    // First capture: addi x1,x0,-4
    drive(32'hFFC0_0093, 32'h0000_0100);
    tick();
    in_valid = 1'b0;
    check("addi_valid", {31'b0, out_valid}, 32'h1);
    check("addi_type", {29'b0, imm_type}, 32'h4);
    check("addi_immI", imm_I, 32'hFFFF_FFFC);
    check("addi_ill", {31'b0, illegal}, 32'h0);

    // Back-to-back lui / jal / sw
    drive(32'h1234_50B7, 32'h0000_0104);
    tick();
    check("lui_type", {29'b0, imm_type}, 32'h1);
    check("lui_immU", imm_U, 32'h1234_5000);
    drive(32'hFF1F_F06F, 32'h0000_0108);
    tick();
    check("jal_type", {29'b0, imm_type}, 32'h0);
    check("jal_immJ", imm_J, 32'hFFFF_FFF0);
    drive(32'hFE20_AE23, 32'h0000_010C);
    tick();
    check("sw_type", {29'b0, imm_type}, 32'h3);
    check("sw_immS", imm_S, 32'hFFFF_FFFC);

    // Stall three cycles with the next instruction pending
    out_ready = 1'b0;
    drive(32'h0051_0113, 32'h0000_0110);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check("stall_instr", instr_out, 32'hFE20_AE23);
      check("stall_pc", pc_out, 32'h0000_010C);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("unstall_instr", instr_out, 32'h0051_0113);
    check("unstall_valid", {31'b0, out_valid}, 32'h1);
    tick();
    check("no_dup_valid", {31'b0, out_valid}, 32'h0);

    // Flush together with an incoming instruction while one is held
    out_ready = 1'b0;
    drive(32'h00A0_0093, 32'h0000_0200);
    tick();
    flush = 1'b1;
    drive(32'h0030_0193, 32'h0000_0204);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    check("flush_instr", instr_out, 32'h0000_0013);
    check("flush_type", {29'b0, imm_type}, 32'h5);
    check("flush_ill", {31'b0, illegal}, 32'h0);

    // Illegal opcode, then a legal type-none instruction
    out_ready = 1'b1;
    drive(32'h0000_007F, 32'h0000_0300);
    tick();
    check("illop_type", {29'b0, imm_type}, 32'h5);
    check("illop_ill", {31'b0, illegal}, 32'h1);
    drive(32'h0020_80B3, 32'h0000_0304);
    tick();
    in_valid = 1'b0;
    check("add_type", {29'b0, imm_type}, 32'h5);
    check("add_ill", {31'b0, illegal}, 32'h0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive(32'h8000_0063, 32'h0000_0400);
    tick();
    drive(32'h0000_0013, 32'h0000_0404);
    tick();
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_vals("arst");
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // First capture after reset release
    drive(32'hFFC0_0093, 32'h0000_0500);
    tick();
    in_valid = 1'b0;
    check("post_valid", {31'b0, out_valid}, 32'h1);
    check("post_type", {29'b0, imm_type}, 32'h4);
    check("post_immI", imm_I, 32'hFFFF_FFFC);
    check("post_ill", {31'b0, illegal}, 32'h0);
    tick();
    tick();
    check("sb_empty", sb_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered decode-side stage directly upstream of imm_mux. It accepts a fetched instruction and PC over a valid/ready handshake and decodes the opcode into imm_type. It extracts all five sign-extended immediates (J, U, B, S, I) and presents them, registered, to imm_mux and the downstream execute logic. It holds one instruction and supports stall (backpressure) and synchronous flush.

Parameters:
NOP_INSTR, 32'h00000013, instruction word driven on instr_out after reset or flush (addi x0,x0,0).
RESET_PC, 32'h00000000, value of pc_out after reset.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
instr_in  in  32  fetched instruction word.
pc_in  in  32  PC of instr_in.
in_valid  in  1  instr_in/pc_in valid.
in_ready  out  1  stage can accept this cycle.
flush  in  1  synchronous kill of the held/incoming instruction.
out_ready  in  1  downstream consumes the held instruction this cycle.
out_valid  out  1  registered outputs hold a live instruction.
instr_out  out  32  registered instruction.
pc_out  out  32  registered PC.
imm_type  out  3  000 J, 001 U, 010 B, 011 S, 100 I, 101 none.
imm_J, imm_U, imm_B, imm_S, imm_I  out  32 each  registered immediates.
illegal  out  1  opcode not recognised (registered, qualified by out_valid).

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, illegal=0, instr_out=NOP_INSTR, pc_out=RESET_PC, imm_type=101, all imm_*=0. Takes effect immediately, including mid-transfer. The held instruction is lost.
- in_ready = !out_valid || out_ready (combinational). It ignores flush.
- Capture when in_valid && in_ready && !flush. On the next edge: registers load, out_valid=1. Latency is 1 cycle.
- Consume without a new capture: out_valid=0 on the next edge. Data registers hold their last value.
- Stall (out_valid=1, out_ready=0): all outputs hold stable and in_ready=0.
- Simultaneous consume and capture: back-to-back, out_valid stays 1 and the new data is loaded. Full throughput is 1 instruction/cycle.
- flush=1: on the next edge out_valid=0, instr_out=NOP_INSTR, imm_type=101, illegal=0. Flush has priority over capture and over stall. The PC and immediate registers may hold.
- Opcode decode on instr_in[6:0]:
  - 1101111 JAL -> 000.
  - 0110111 LUI and 0010111 AUIPC -> 001.
  - 1100011 BRANCH -> 010.
  - 0100011 STORE -> 011.
  - 0010011 OP-IMM, 0000011 LOAD and 1100111 JALR -> 100.
  - 0110011 OP, 0001111 FENCE and 1110011 SYSTEM -> 101.
  - Anything else -> 101 with illegal=1.
- Immediates are computed for every captured instruction regardless of type (x=instr_in):
  - I = {20{x[31]}, x[31:20]}
  - S = {20{x[31]}, x[31:25], x[11:7]}
  - B = {19{x[31]}, x[31], x[7], x[30:25], x[11:8], 0}
  - U = {x[31:12], 12'b0}
  - J = {11{x[31]}, x[31], x[19:12], x[20], x[30:21], 0}
- No combinational path from instr_in to any output. in_ready depends only on out_valid and out_ready.

Test Plan:
- Reset then 0xFFC00093 (addi x1,x0,-4) with in_valid=1 and out_ready=1 -> next cycle out_valid=1, imm_type=100, imm_I=0xFFFFFFFC, illegal=0.
- Back-to-back 0x123450B7 (lui), 0xFF1FF06F (jal x0,-16), 0xFE20AE23 (sw x2,-4(x1)) -> consecutive cycles:
  - imm_type=001 with imm_U=0x12345000.
  - imm_type=000 with imm_J=0xFFFFFFF0.
  - imm_type=011 with imm_S=0xFFFFFFFC.
- Stall: hold out_ready=0 for 3 cycles with the next instruction pending -> in_ready=0 and outputs unchanged. Raise out_ready -> pending instruction appears the following cycle, with none dropped or duplicated.
- flush=1 together with in_valid=1 while out_valid=1 -> next cycle out_valid=0, instr_out=0x00000013, imm_type=101.
- 0x0000007F with in_valid=1 -> imm_type=101, illegal=1. Then 0x002080B3 (add) -> imm_type=101, illegal=0.
- Assert rst_n=0 between clock edges during a stall -> outputs go to reset values immediately without a clock edge. After release, the first capture behaves as in the first scenario.
